tc_clk_gate_ctrl: RTL and testbench

//  Drives en_i of a tc_clk_gating cell; this block is the enable source for that cell.

---
 rtl/tc_clk_gate_ctrl.sv | 134 +++++++++++++
 tb/tb_tc_clk_gate_ctrl.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/tc_clk_gate_ctrl.sv
// tc_clk_gate_ctrl
//   Enable source for a tc_clk_gating cell. Counts idle cycles of the
//   downstream domain, runs a 4-phase sleep handshake (sleep_req_o /
//   sleep_ack_i), and drops the clock enable only once the domain has
//   acknowledged. On wake it restores the enable first and raises ready_o
//   after a fixed settle time. Lives in the always-on clock domain.
//
// Parameters
//   IdleCycles  consecutive idle cycles before a sleep request (>= 1)
//   WakeCycles  cycles from clk_en_o rising to ready_o rising (>= 0)
//
// Ports
//   clk_i        free-running (ungated) clock
//   rst_i        synchronous reset, active-high
//   enable_i     permit auto-gating; low forces the clock on
//   activity_i   downstream domain busy this cycle
//   wake_i       wake request
//   sleep_req_o  request to the domain to quiesce
//   sleep_ack_i  domain quiesced (4-phase partner of sleep_req_o)
//   clk_en_o     enable to the gating cell
//   ready_o      domain clocked and usable
//   gated_o      clock currently gated (status)
module tc_clk_gate_ctrl #(
    parameter int IdleCycles = 16,
    parameter int WakeCycles = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic enable_i,
    input  logic activity_i,
    input  logic wake_i,
    output logic sleep_req_o,
    input  logic sleep_ack_i,
    output logic clk_en_o,
    output logic ready_o,
    output logic gated_o
);

    localparam int MaxCnt = (IdleCycles > WakeCycles) ? IdleCycles : WakeCycles;
    localparam int CntW   = $clog2(MaxCnt + 1);

    typedef enum logic [1:0] {
        RUN,
        SLEEP_REQ,
        GATED,
        WAKE
    } state_t;

    state_t          state;
    logic [CntW-1:0] cnt;
    logic [CntW-1:0] cnt_inc;
    logic            idle;
    logic            abort;
    logic            idle_last;
    logic            wake_last;

    assign idle  = enable_i & ~activity_i & ~wake_i;
    assign abort = ~enable_i | activity_i | wake_i;

    // Saturating increment: the counter never wraps.
    assign cnt_inc = (cnt == '1) ? cnt : cnt + 1'b1;

    // True on the edge that samples the final idle / settle cycle.
    assign idle_last = (int'(cnt) + 1) >= IdleCycles;
    assign wake_last = (int'(cnt) + 1) >= WakeCycles;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= RUN;
            cnt         <= '0;
            clk_en_o    <= 1'b1;
            ready_o     <= 1'b1;
            sleep_req_o <= 1'b0;
            gated_o     <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    // A lingering ack from the previous handshake holds the
                    // count at zero, which blocks a new request until it drops.
                    if (idle && !sleep_ack_i) begin
                        if (idle_last) begin
                            state       <= SLEEP_REQ;
                            cnt         <= '0;
                            sleep_req_o <= 1'b1;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end else begin
                        cnt <= '0;
                    end
                end
                SLEEP_REQ: begin
                    // Abort wins over a simultaneous acknowledge.
                    if (abort) begin
                        state       <= RUN;
                        cnt         <= '0;
                        sleep_req_o <= 1'b0;
                    end else if (sleep_ack_i) begin
                        state    <= GATED;
                        clk_en_o <= 1'b0;
                        ready_o  <= 1'b0;
                        gated_o  <= 1'b1;
                    end
                end
                GATED: begin
                    // activity_i is meaningless here: the domain has no clock.
                    if (wake_i || !enable_i) begin
                        state       <= WAKE;
                        cnt         <= '0;
                        clk_en_o    <= 1'b1;
                        sleep_req_o <= 1'b0;
                        gated_o     <= 1'b0;
                        // With no settle time ready rises together with the enable.
                        ready_o     <= (WakeCycles == 0);
                    end
                end
                WAKE: begin
                    if (wake_last) begin
                        state   <= RUN;
                        cnt     <= '0;
                        ready_o <= 1'b1;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                default: begin
                    state <= RUN;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tc_clk_gate_ctrl.sv
module tb_tc_clk_gate_ctrl;

    typedef struct {
        string      name;
        logic [3:0] v;      // {clk_en_o, ready_o, sleep_req_o, gated_o}
    } exp_t;

    localparam logic [3:0] RUN_O = 4'b1100;
    localparam logic [3:0] REQ_O = 4'b1110;
    localparam logic [3:0] GAT_O = 4'b0011;
    localparam logic [3:0] WAK_O = 4'b1000;

    logic clk = 1'b0;
    logic rst_i = 1'b1;
    logic enable_i = 1'b1;
    logic activity_i = 1'b0;
    logic wake_i = 1'b0;
    logic sleep_ack_i = 1'b0;
    logic sleep_req_o, clk_en_o, ready_o, gated_o;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    tc_clk_gate_ctrl #(
        .IdleCycles(4),
        .WakeCycles(2)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .enable_i   (enable_i),
        .activity_i (activity_i),
        .wake_i     (wake_i),
        .sleep_req_o(sleep_req_o),
        .sleep_ack_i(sleep_ack_i),
        .clk_en_o   (clk_en_o),
        .ready_o    (ready_o),
        .gated_o    (gated_o)
    );

    // Drive one cycle of inputs and queue the outputs expected after that edge.
    task automatic step(input logic r, input logic en, input logic act,
                        input logic wk, input logic ack,
                        input logic [3:0] e, input string nm);
        exp_t x;
        @(negedge clk);
        rst_i       = r;
        enable_i    = en;
        activity_i  = act;
        wake_i      = wk;
        sleep_ack_i = ack;
        @(posedge clk);
        x.name = nm;
        x.v    = e;
        exp_q.push_back(x);
    endtask

    // n idle cycles with ack low; the n-th is expected to raise sleep_req_o
    // when last_req is set.
    task automatic idle_n(input int n, input logic last_req, input string nm);
        for (int i = 1; i <= n; i++)
            step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0,
                 (last_req && i == n) ? REQ_O : RUN_O, nm);
    endtask

    // Monitor: outputs are registered, so sample on the falling edge.
    initial begin
        exp_t x;
        logic [3:0] got;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                x   = exp_q.pop_front();
                got = {clk_en_o, ready_o, sleep_req_o, gated_o};
                n_checks++;
                if (got !== x.v) begin
                    n_fail++;
                    $display("FAIL %s: got {en,rdy,req,gated}=%b expected %b at %0t",
                             x.name, got, x.v, $time);
                end
            end
        end
    end

    initial begin
        int budget;
        // Reset
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, RUN_O, "reset");

        // 1: four idle edges after release -> request
        idle_n(4, 1'b1, "t1_idle_to_req");

        // 2: ack -> gated; activity ignored while gated
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, GAT_O, "t2_gate");
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, GAT_O, "t2_act_ignored");

        // 3: wake pulse -> enable next, ready two cycles later
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, WAK_O, "t3_wake_en");
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, WAK_O, "t3_settle");
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, RUN_O, "t3_ready");

        // 4: abort priority over ack, then count restarts from zero
        idle_n(4, 1'b1, "t4_req");
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, RUN_O, "t4_act_abort");
        idle_n(4, 1'b1, "t4_restart");
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, RUN_O, "t4_wake_abort");
        idle_n(4, 1'b1, "t4_req2");
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, RUN_O, "t4_disable_abort");

        // 5: broken idle run gives no request; disable wakes from gated
        idle_n(3, 1'b0, "t5_idle3");
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, RUN_O, "t5_active");
        idle_n(3, 1'b0, "t5_no_req");
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, REQ_O, "t5_req");
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, GAT_O, "t5_gate");
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, WAK_O, "t5_dis_wake");
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, WAK_O, "t5_settle");
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, RUN_O, "t5_ready");

        // 6: reset in gated and in wake; held ack blocks a new request
        idle_n(4, 1'b1, "t6_req");
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, GAT_O, "t6_gate");
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, RUN_O, "t6_rst_gated");
        for (int i = 0; i < 5; i++)
            step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, RUN_O, "t6_ack_blocks");
        idle_n(4, 1'b1, "t6_rerequest");
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, GAT_O, "t6_gate2");
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, WAK_O, "t6_wake");
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, RUN_O, "t6_rst_wake");
        for (int i = 0; i < 4; i++)
            step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, RUN_O, "t6_ack_blocks2");
        idle_n(4, 1'b1, "t6_rerequest2");

        // Drain the scoreboard with a bounded wait.
        budget = 0;
        while (exp_q.size() > 0 && budget < 20) begin
            @(posedge clk);
            budget++;
        end
        if (exp_q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d entries left, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
